// File: rtl/conv_seq_pkg.sv
// Shared types and constants for the convolution sequencer: FSM states, mode codes,
// output-window base addresses and the registered output bundle.
package conv_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    WAIT,
    FLUSH,
    READ,
    DONE
  } state_t;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_2BY2   = 2'd1;
  localparam logic [1:0] MODE_3BY3   = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  localparam int FILTER_SIZE = 9;
  localparam int NUM_OUT     = 4;

  // Top-left input address of the 3x3 window for C11, C12, C21, C22.
  localparam logic [4:0] WIN_BASE [NUM_OUT] = '{5'd0, 5'd1, 5'd4, 5'd5};

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       out_valid;
    logic [1:0] out_idx;
    logic [4:0] in_single;
    logic [4:0] fil_single;
    logic       en_single;
    logic [3:0] we_single;
    logic [1:0] rd_single;
    logic [4:0] in_2by2;
    logic [4:0] fil1_2by2;
    logic [4:0] fil2_2by2;
    logic [1:0] rd_2by2;
    logic       en_2by2;
    logic [4:0] in_side_3by3;
    logic [4:0] in_ceil_3by3;
    logic [4:0] fil_side_3by3;
    logic [4:0] fil_ceil_3by3;
    logic [1:0] rd_3by3;
    logic       en_3by3;
  } seq_out_t;

endpackage

// File: rtl/conv_seq_addr_gen.sv
// Single-PE input address: window base of output k plus the row/column offset of
// filter tap s inside a 4-wide input image.
module conv_seq_addr_gen
  import conv_seq_pkg::*;
(
  input  logic [1:0] k,
  input  logic [3:0] s,
  output logic [4:0] addr
);

  logic [4:0] row_off;
  logic [4:0] col;

  always_comb begin
    if (s >= 4'd6) begin
      row_off = 5'd8;
      col     = 5'(s - 4'd6);
    end else if (s >= 4'd3) begin
      row_off = 5'd4;
      col     = 5'(s - 4'd3);
    end else begin
      row_off = 5'd0;
      col     = 5'(s);
    end
    addr = WIN_BASE[k] + row_off + col;
  end

endmodule

// File: rtl/conv_sequencer.sv
// Convolution job controller: sequences single-PE, 2x2 and 3x3 datapaths and
// reads the four results back. Outputs are registered from the next-state view.
module conv_sequencer
  import conv_seq_pkg::*;
#(
  parameter int PIPE_LAT  = 2,
  parameter int FEED_2BY2 = 7,
  parameter int FEED_3BY3 = 7,
  parameter int DRAIN     = 4,
  parameter int READ_LAT  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  output logic       busy,
  output logic       done,
  output logic       out_valid,
  output logic [1:0] out_idx,
  output logic [4:0] input_array_addr_in_single,
  output logic [4:0] filter_ceiling_array_addr_in_single,
  output logic       sys_single_en,
  output logic       buffer_we_en_C11_single,
  output logic       buffer_we_en_C12_single,
  output logic       buffer_we_en_C21_single,
  output logic       buffer_we_en_C22_single,
  output logic [1:0] buffer_read_addr_in_single,
  output logic [4:0] input_array_addr_in_2by2,
  output logic [4:0] filter_ceiling_first_array_addr_in_2by2,
  output logic [4:0] filter_ceiling_second_array_addr_in_2by2,
  output logic [1:0] buffer_read_addr_in_2by2,
  output logic       sys_2by2_en,
  output logic [4:0] input_side_array_addr_in_3by3,
  output logic [4:0] input_ceiling_array_addr_in_3by3,
  output logic [4:0] filter_side_array_addr_in_3by3,
  output logic [4:0] filter_ceiling_array_addr_in_3by3,
  output logic [1:0] buffer_read_addr_in_3by3,
  output logic       sys_3by3_en
);

  localparam logic [7:0] S_LAST     = 8'(FILTER_SIZE - 1);
  localparam logic [7:0] PIPE_LAST  = 8'(PIPE_LAT - 1);
  localparam logic [7:0] FEED2_LAST = 8'(FEED_2BY2 - 1);
  localparam logic [7:0] FEED3_LAST = 8'(FEED_3BY3 - 1);
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN - 1);
  localparam logic [7:0] READ_LAST  = 8'(NUM_OUT - 1 + READ_LAT);
  localparam logic [7:0] RD_LAT     = 8'(READ_LAT);

  state_t     state, state_n;
  logic [1:0] mode_q, mode_n;
  logic [1:0] k, k_n;
  logic [7:0] cnt, cnt_n;
  logic [7:0] feed_last;
  logic [4:0] single_addr;
  logic       run_n, read_n;
  seq_out_t   nxt, q;

  assign feed_last = (mode_q == MODE_2BY2) ? FEED2_LAST : FEED3_LAST;

  always_comb begin
    state_n = state;
    mode_n  = mode_q;
    k_n     = k;
    cnt_n   = cnt;
    case (state)
      IDLE: if (start && mode != MODE_RSVD) begin
        state_n = RUN;
        mode_n  = mode;
        k_n     = 2'd0;
        cnt_n   = 8'd0;
      end
      RUN: if (mode_q == MODE_SINGLE) begin
        if (cnt >= S_LAST) begin
          state_n = WAIT;
          cnt_n   = 8'd0;
        end else cnt_n = cnt + 8'd1;
      end else if (cnt >= feed_last) begin
        state_n = FLUSH;
        cnt_n   = 8'd0;
      end else cnt_n = cnt + 8'd1;
      WAIT: if (cnt >= PIPE_LAST) begin
        cnt_n = 8'd0;
        if (k == 2'd3) state_n = READ;
        else begin
          state_n = RUN;
          k_n     = k + 2'd1;
        end
      end else cnt_n = cnt + 8'd1;
      FLUSH: if (cnt >= DRAIN_LAST) begin
        state_n = READ;
        cnt_n   = 8'd0;
      end else cnt_n = cnt + 8'd1;
      READ: if (cnt >= READ_LAST) begin
        state_n = DONE;
        cnt_n   = 8'd0;
      end else cnt_n = cnt + 8'd1;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  conv_seq_addr_gen u_addr_gen (
    .k    (k_n),
    .s    (cnt_n[3:0]),
    .addr (single_addr)
  );

  // Output decode works on the next state so the registered outputs line up with it.
  always_comb begin
    nxt      = '0;
    run_n    = (state_n == RUN);
    read_n   = (state_n == READ) && (cnt_n < 8'(NUM_OUT));
    nxt.busy = (state_n == RUN) || (state_n == WAIT) || (state_n == FLUSH) || (state_n == READ);
    nxt.done = (state_n == DONE);
    if ((state_n == READ) && (cnt_n >= RD_LAT)) begin
      nxt.out_valid = 1'b1;
      nxt.out_idx   = 2'(cnt_n - RD_LAT);
    end
    case (mode_n)
      MODE_SINGLE: begin
        if (run_n) begin
          nxt.en_single  = 1'b1;
          nxt.in_single  = single_addr;
          nxt.fil_single = 5'(cnt_n);
        end
        if ((state_n == WAIT) && (cnt_n == PIPE_LAST)) nxt.we_single[k_n] = 1'b1;
        if (read_n) nxt.rd_single = cnt_n[1:0];
      end
      MODE_2BY2: begin
        if (run_n) begin
          nxt.in_2by2   = 5'(cnt_n);
          nxt.fil1_2by2 = 5'(cnt_n);
          nxt.fil2_2by2 = 5'(cnt_n);
        end
        nxt.en_2by2 = run_n || (state_n == FLUSH);
        if (read_n) nxt.rd_2by2 = cnt_n[1:0];
      end
      MODE_3BY3: begin
        if (run_n) begin
          nxt.in_side_3by3  = 5'(cnt_n);
          nxt.in_ceil_3by3  = 5'(cnt_n);
          nxt.fil_side_3by3 = 5'(cnt_n);
          nxt.fil_ceil_3by3 = 5'(cnt_n);
        end
        nxt.en_3by3 = run_n || (state_n == FLUSH);
        if (read_n) nxt.rd_3by3 = cnt_n[1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mode_q <= MODE_SINGLE;
      k      <= 2'd0;
      cnt    <= 8'd0;
      q      <= '0;
    end else begin
      state  <= state_n;
      mode_q <= mode_n;
      k      <= k_n;
      cnt    <= cnt_n;
      q      <= nxt;
    end
  end

  assign busy                                     = q.busy;
  assign done                                     = q.done;
  assign out_valid                                = q.out_valid;
  assign out_idx                                  = q.out_idx;
  assign input_array_addr_in_single               = q.in_single;
  assign filter_ceiling_array_addr_in_single      = q.fil_single;
  assign sys_single_en                            = q.en_single;
  assign buffer_we_en_C11_single                  = q.we_single[0];
  assign buffer_we_en_C12_single                  = q.we_single[1];
  assign buffer_we_en_C21_single                  = q.we_single[2];
  assign buffer_we_en_C22_single                  = q.we_single[3];
  assign buffer_read_addr_in_single               = q.rd_single;
  assign input_array_addr_in_2by2                 = q.in_2by2;
  assign filter_ceiling_first_array_addr_in_2by2  = q.fil1_2by2;
  assign filter_ceiling_second_array_addr_in_2by2 = q.fil2_2by2;
  assign buffer_read_addr_in_2by2                 = q.rd_2by2;
  assign sys_2by2_en                              = q.en_2by2;
  assign input_side_array_addr_in_3by3            = q.in_side_3by3;
  assign input_ceiling_array_addr_in_3by3         = q.in_ceil_3by3;
  assign filter_side_array_addr_in_3by3           = q.fil_side_3by3;
  assign filter_ceiling_array_addr_in_3by3        = q.fil_ceil_3by3;
  assign buffer_read_addr_in_3by3                 = q.rd_3by3;
  assign sys_3by3_en                              = q.en_3by3;

endmodule
